// File: rtl/gradient_mag_dir_if.sv
// Purpose: bundles the start/done control, the Gx/Gy gradient buffers and the
//          magnitude/direction result buffers of gradient_mag_dir.
// Ports (signals):
//   startMag  master->slave  start request
//   gradHor   master->slave  Gx buffer, NUM_PIX x GW, two's complement
//   gradVer   master->slave  Gy buffer, NUM_PIX x GW, two's complement
//   busy      slave->master  high while a run is in progress
//   magDone   slave->master  one-cycle pulse, result buffers complete
//   magOut    slave->master  magnitude buffer, NUM_PIX x MW
//   dirOut    slave->master  direction code buffer, NUM_PIX x 2
// Handshake: startMag is a request that the slave accepts only while idle (busy
// low at the sampling edge); once accepted, gradHor/gradVer must stay stable
// until magDone pulses. magDone is high for exactly one cycle, and busy drops
// on the edge that ends that cycle. Requests made while busy are dropped.
interface gradient_mag_dir_if #(
    parameter int NUM_PIX = 26,
    parameter int GW      = 13,
    parameter int MW      = 8
);
    logic                          startMag;
    logic [NUM_PIX-1:0][GW-1:0]    gradHor;
    logic [NUM_PIX-1:0][GW-1:0]    gradVer;
    logic                          busy;
    logic                          magDone;
    logic [NUM_PIX-1:0][MW-1:0]    magOut;
    logic [NUM_PIX-1:0][1:0]       dirOut;

    modport master (
        output startMag, gradHor, gradVer,
        input  busy, magDone, magOut, dirOut
    );

    modport slave (
        input  startMag, gradHor, gradVer,
        output busy, magDone, magOut, dirOut
    );
endinterface

// File: rtl/gradient_mag_dir.sv
// Purpose: Canny stage 3. For each pixel of the Sobel gradient buffers,
//          computes a scaled, saturated L1 magnitude and a direction
//          quantised to 0/45/90/135 degrees, one pixel per cycle through a
//          two-stage pipeline.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-low
//   bus      gradient_mag_dir_if.slave (start/done, gradient and result buffers)
//   state_o  current FSM state, for observation
module gradient_mag_dir #(
    parameter int NUM_PIX   = 26,
    parameter int GW        = 13,
    parameter int MW        = 8,
    parameter int MAG_SHIFT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    gradient_mag_dir_if.slave      bus,
    output logic [1:0]             state_o
);
    localparam int IDXW = $clog2(NUM_PIX);
    localparam int SW   = GW + 1;
    localparam int PW   = GW + 10;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_PIX - 1);
    localparam logic [SW-1:0]   SAT      = SW'((1 << MW) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [IDXW-1:0]            idx_q, idx_d;
    logic                       busy_q, done_q;

    // Stage 1 registers
    logic                       s1_vld_q;
    logic [IDXW-1:0]            s1_idx_q;
    logic [GW-1:0]              ax_q, ay_q;
    logic                       sx_q, sy_q;

    // Result buffers
    logic [NUM_PIX-1:0][MW-1:0] mag_q;
    logic [NUM_PIX-1:0][1:0]    dir_q;

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.startMag) begin
                    state_d = CALC;
                    idx_d   = '0;
                end
            end
            CALC: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                    idx_d   = '0;  // keeps idx inside the buffer range
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- Stage 1: absolute values and signs ----------------
    logic [GW-1:0] gx, gy, ax_d, ay_d;

    always_comb begin
        gx   = bus.gradHor[idx_q];
        gy   = bus.gradVer[idx_q];
        // -2^(GW-1) negates to 2^(GW-1), which is representable as unsigned GW bits
        ax_d = gx[GW-1] ? (~gx + GW'(1)) : gx;
        ay_d = gy[GW-1] ? (~gy + GW'(1)) : gy;
    end

    // ---------------- Stage 2: magnitude and direction ----------------
    logic [SW-1:0] sum, shf;
    logic [MW-1:0] mag;
    logic [PW-1:0] ay256, ax106, ax618;
    logic [1:0]    dir;

    always_comb begin
        sum   = SW'(ax_q) + SW'(ay_q);
        shf   = sum >> MAG_SHIFT;
        mag   = (shf > SAT) ? {MW{1'b1}} : shf[MW-1:0];
        // tan(22.5) ~ 106/256 and tan(67.5) ~ 618/256, compared without division
        ay256 = PW'(ay_q) << 8;
        ax106 = PW'(ax_q) * PW'(106);
        ax618 = PW'(ax_q) * PW'(618);
        if (ay256 <= ax106) begin
            dir = 2'd0;
        end else if (ay256 >= ax618) begin
            dir = 2'd2;
        end else if (sx_q == sy_q) begin
            dir = 2'd1;
        end else begin
            dir = 2'd3;
        end
    end

    // ---------------- Registers ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_idx_q <= '0;
            ax_q     <= '0;
            ay_q     <= '0;
            sx_q     <= 1'b0;
            sy_q     <= 1'b0;
            mag_q    <= '0;
            dir_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            // Registered from next state so busy/magDone line up with the state
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
            s1_vld_q <= (state_q == CALC);
            if (state_q == CALC) begin
                s1_idx_q <= idx_q;
                ax_q     <= ax_d;
                ay_q     <= ay_d;
                sx_q     <= gx[GW-1];
                sy_q     <= gy[GW-1];
            end
            if (s1_vld_q) begin
                mag_q[s1_idx_q] <= mag;
                dir_q[s1_idx_q] <= dir;
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.magDone = done_q;
    assign bus.magOut  = mag_q;
    assign bus.dirOut  = dir_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_gradient_mag_dir.sv
module tb_gradient_mag_dir;
  localparam int NUM_PIX = 26;
  localparam int GW      = 13;
  localparam int MW      = 8;
  localparam int LAT     = NUM_PIX + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gradient_mag_dir_if #(.NUM_PIX(NUM_PIX), .GW(GW), .MW(MW)) bus ();
  logic [1:0] state_dbg;

  gradient_mag_dir #(.NUM_PIX(NUM_PIX), .GW(GW), .MW(MW), .MAG_SHIFT(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_dbg)
  );

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void model_pix(input int gx, input int gy, output int m, output int d);
    int ax, ay, s;
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    s  = (ax + ay) / 8;
    m  = (s > 255) ? 255 : s;
    if (ay * 256 <= ax * 106)      d = 0;
    else if (ay * 256 >= ax * 618) d = 2;
    else if ((gx < 0) == (gy < 0)) d = 1;
    else                           d = 3;
  endfunction

  bit running = 1'b0;
  int cyc = 0;
  logic [NUM_PIX-1:0][MW-1:0] exp_mag = '0;
  logic [NUM_PIX-1:0][1:0]    exp_dir = '0;
  bit exp_busy = 1'b0;
  bit exp_done = 1'b0;

  // Timing model: a run accepted at edge E0 writes pixel i at E0+2+i, signals
  // done in the cycle after E0+NUM_PIX+1, and is idle again from E0+NUM_PIX+2.
  initial begin
    int m, d, p;
    forever begin
      @(posedge clk);
      if (!reset) begin
        running = 1'b0;
        cyc     = 0;
        exp_mag = '0;
        exp_dir = '0;
      end else if (running) begin
        cyc++;
        if (cyc >= 2 && cyc <= NUM_PIX + 1) begin
          p = cyc - 2;
          model_pix(int'($signed(bus.gradHor[p])), int'($signed(bus.gradVer[p])), m, d);
          exp_mag[p] = MW'(m);
          exp_dir[p] = 2'(d);
        end
        if (cyc == NUM_PIX + 2) running = 1'b0;
      end else if (bus.startMag) begin
        running = 1'b1;
        cyc     = 0;
      end
      exp_busy = running;
      exp_done = running && (cyc == NUM_PIX + 1);
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        check("busy", 256'(bus.busy), 256'(exp_busy));
        check("magDone", 256'(bus.magDone), 256'(exp_done));
        check("magOut", 256'(bus.magOut), 256'(exp_mag));
        check("dirOut", 256'(bus.dirOut), 256'(exp_dir));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_pix(input int i, input int gx, input int gy);
    bus.gradHor[i] = GW'(gx);
    bus.gradVer[i] = GW'(gy);
  endtask

  // Raises start for one edge; returns at the negedge after the accepting edge.
  task automatic start_run();
    bus.startMag = 1'b1;
    @(negedge clk);
    bus.startMag = 1'b0;
  endtask

  // n = edges since the accepting edge already elapsed; returns at the magDone negedge.
  task automatic wait_done(input int n0, input int b0, output int n, output int nb);
    n  = n0;
    nb = b0;
    while (!bus.magDone && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.busy) nb++;
    end
  endtask

  task automatic run_full(input string name);
    int n, nb;
    start_run();
    wait_done(1, bus.busy ? 1 : 0, n, nb);
    check({name, "_latency"}, 256'(n), 256'(LAT));
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, nb;
    bus.startMag = 1'b0;
    bus.gradHor  = '0;
    bus.gradVer  = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_done", 256'(bus.magDone), 256'(0));
    check("rst_mag", 256'(bus.magOut), 256'(0));
    check("rst_dir", 256'(bus.dirOut), 256'(0));
    reset = 1'b1;
    @(negedge clk);

    // 1: all-zero gradients
    start_run();
    wait_done(1, bus.busy ? 1 : 0, n, nb);
    check("t1_latency", 256'(n), 256'(28));
    check("t1_busy_cycles", 256'(nb), 256'(28));
    @(negedge clk);
    check("t1_mag", 256'(bus.magOut), 256'(0));
    check("t1_dir", 256'(bus.dirOut), 256'(0));

    // 2: saturation and 45/135 with pixel-0 write timing
    for (int i = 0; i < NUM_PIX; i++) set_pix(i, i * 50 - 600, 300 - i * 17);
    set_pix(0, 1020, 1020);
    set_pix(1, -1020, 1020);
    start_run();
    check("t2_pix0_e0", 256'(bus.magOut[0]), 256'(0));
    @(negedge clk);
    check("t2_pix0_e1", 256'(bus.magOut[0]), 256'(0));
    @(negedge clk);
    check("t2_pix0_e2_mag", 256'(bus.magOut[0]), 256'(255));
    check("t2_pix0_e2_dir", 256'(bus.dirOut[0]), 256'(1));
    wait_done(3, 3, n, nb);
    check("t2_latency", 256'(n), 256'(28));
    @(negedge clk);
    check("t2_pix1_mag", 256'(bus.magOut[1]), 256'(255));
    check("t2_pix1_dir", 256'(bus.dirOut[1]), 256'(3));

    // 3: direction thresholds
    set_pix(0, 100, 41);
    set_pix(1, 100, 42);
    set_pix(2, 10, 25);
    set_pix(3, 10, 24);
    run_full("t3");
    check("t3_dir0", 256'(bus.dirOut[0]), 256'(0));
    check("t3_dir1", 256'(bus.dirOut[1]), 256'(1));
    check("t3_dir2", 256'(bus.dirOut[2]), 256'(2));
    check("t3_dir3", 256'(bus.dirOut[3]), 256'(1));

    // 4: most-negative input and small magnitude
    set_pix(0, -4096, -4096);
    set_pix(1, 8, -7);
    run_full("t4");
    check("t4_mag0", 256'(bus.magOut[0]), 256'(255));
    check("t4_dir0", 256'(bus.dirOut[0]), 256'(1));
    check("t4_mag1", 256'(bus.magOut[1]), 256'(1));
    check("t4_dir1", 256'(bus.dirOut[1]), 256'(3));

    // 5: start during CALC ignored; start raised on the magDone cycle
    start_run();
    repeat (5) @(negedge clk);
    bus.startMag = 1'b1;
    @(negedge clk);
    bus.startMag = 1'b0;
    wait_done(7, 7, n, nb);
    check("t5_latency", 256'(n), 256'(28));
    bus.startMag = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.startMag = 1'b0;
    wait_done(1, 1, n, nb);
    check("t5_b2b_latency", 256'(n), 256'(28));
    @(negedge clk);

    // 6: reset in mid-run at idx 10
    start_run();
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_busy", 256'(bus.busy), 256'(0));
    check("t6_done", 256'(bus.magDone), 256'(0));
    check("t6_mag", 256'(bus.magOut), 256'(0));
    check("t6_dir", 256'(bus.dirOut), 256'(0));
    reset = 1'b1;
    @(negedge clk);
    run_full("t6_after");
    check("t6_mag0", 256'(bus.magOut[0]), 256'(255));
    check("t6_mag1", 256'(bus.magOut[1]), 256'(1));

    repeat (2) @(negedge clk);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
